// File: rtl/pdetect_pkg.sv
// Shared constants and types for the sync-word stream framer and the
// pattern detector that consumes its output.
package pdetect_pkg;

    localparam logic [31:0] PATTERN_DEFAULT = 32'h0A0B0C0D;
    localparam int unsigned SYNC_BYTES      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    // Sync bytes go out most-significant byte first.
    function automatic logic [7:0] sync_byte(input logic [31:0] pattern, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = pattern[31:24];
            2'd1:    b = pattern[23:16];
            2'd2:    b = pattern[15:8];
            default: b = pattern[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single ready/valid output register stage: loads only when its slot is free
// and drops valid when the slot frees up with nothing new to load.
module stream_reg_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign o_free = !valid_q || i_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_load && o_free) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (o_free) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset too, because downstream observes it as 8'h00 after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/pinsert_stream_framer.sv
// Wraps an upstream byte stream into frames: a 4-byte sync word followed by
// PAYLOAD_LEN payload bytes, through a single registered output stage.
module pinsert_stream_framer
    import pdetect_pkg::*;
#(
    parameter logic [31:0] PATTERN     = PATTERN_DEFAULT,
    parameter int unsigned PAYLOAD_LEN = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_m_data,
    input  logic        i_m_valid,
    output logic        o_m_ready,
    output logic [7:0]  o_s_data,
    output logic        o_s_valid,
    input  logic        i_s_ready,
    output logic        o_frame_start,
    output logic [15:0] o_frame_count,
    output logic        o_busy
);

    localparam logic [15:0] LAST_IDX  = 16'(PAYLOAD_LEN - 1);
    localparam logic [1:0]  LAST_SYNC = 2'(SYNC_BYTES - 1);

    state_e      state_q, state_d;
    logic [1:0]  sync_idx_q, sync_idx_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        frame_start_q, frame_start_d;

    logic        slot_free;
    logic        load;
    logic [7:0]  load_data;
    logic        m_ready;

    always_comb begin
        state_d       = state_q;
        sync_idx_d    = sync_idx_q;
        pay_cnt_d     = pay_cnt_q;
        frame_count_d = frame_count_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        load_data     = 8'h00;
        m_ready       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_m_valid) begin
                    state_d    = ST_SYNC;
                    sync_idx_d = '0;
                end
            end
            ST_SYNC: begin
                if (slot_free) begin
                    load          = 1'b1;
                    load_data     = sync_byte(PATTERN, sync_idx_q);
                    frame_start_d = (sync_idx_q == 2'd0);
                    sync_idx_d    = sync_idx_q + 2'd1;
                    if (sync_idx_q == LAST_SYNC) begin
                        state_d   = ST_PAYLOAD;
                        pay_cnt_d = '0;
                    end
                end
            end
            ST_PAYLOAD: begin
                m_ready = slot_free;
                if (i_m_valid && slot_free) begin
                    load      = 1'b1;
                    load_data = i_m_data;
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_cnt_q == LAST_IDX) begin
                        state_d       = ST_IDLE;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            sync_idx_q    <= '0;
            pay_cnt_q     <= '0;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_idx_q    <= sync_idx_d;
            pay_cnt_q     <= pay_cnt_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    stream_reg_slice #(.WIDTH(8)) u_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_data  (load_data),
        .i_ready (i_s_ready),
        .o_valid (o_s_valid),
        .o_data  (o_s_data),
        .o_free  (slot_free)
    );

    // A byte arriving during the reset cycle must not be taken.
    assign o_m_ready     = m_ready && !i_rst;
    assign o_frame_start = frame_start_q;
    assign o_frame_count = frame_count_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pinsert_stream_framer.sv
// Self-checking bench for pinsert_stream_framer: random stimulus compared to a
// frame-level model (sync word + accepted payload bytes) plus a pattern detector.
module tb_pinsert_stream_framer;

    localparam int          LEN = 4;
    localparam logic [31:0] PAT = 32'h0A0B0C0D;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_m_data = 8'h00;
    logic        i_m_valid = 1'b0;
    logic        o_m_ready;
    logic [7:0]  o_s_data;
    logic        o_s_valid;
    logic        i_s_ready = 1'b1;
    logic        o_frame_start;
    logic [15:0] o_frame_count;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int drive_start_cyc = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] acc_q[$];
    int         fs_cyc[$];
    int         det_cyc[$];
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    int         stable_err = 0;
    int         acc_in_rst = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [31:0] det_sr = 32'h0;
    logic        det_pulse = 1'b0;
    logic [15:0] exp_frames = 16'd0;

    pinsert_stream_framer #(.PATTERN(PAT), .PAYLOAD_LEN(LEN)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_m_data      (i_m_data),
        .i_m_valid     (i_m_valid),
        .o_m_ready     (o_m_ready),
        .o_s_data      (o_s_data),
        .o_s_valid     (o_s_valid),
        .i_s_ready     (i_s_ready),
        .o_frame_start (o_frame_start),
        .o_frame_count (o_frame_count),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Downstream 4-byte pattern detector: pulses the cycle after the last pattern byte transfers.
    always @(posedge i_clk) begin
        det_pulse <= 1'b0;
        if (o_s_valid && i_s_ready) begin
            det_sr    <= {det_sr[23:0], o_s_data};
            det_pulse <= ({det_sr[23:0], o_s_data} == PAT);
        end
    end

    // Observer: logs transfers, acceptances, pulses and stall-stability breaks.
    always @(negedge i_clk) begin
        if (i_rst) begin
            if (i_m_valid && o_m_ready) acc_in_rst++;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (o_s_valid !== 1'b1 || o_s_data !== stall_data)) stable_err++;
            if (o_s_valid && i_s_ready) begin
                got_q.push_back(o_s_data);
                got_cyc.push_back(cyc);
            end
            if (i_m_valid && o_m_ready) acc_q.push_back(i_m_data);
            if (o_frame_start) fs_cyc.push_back(cyc);
            if (det_pulse) det_cyc.push_back(cyc);
            stall_prev = o_s_valid && !i_s_ready;
            stall_data = o_s_data;
        end
    end

    function automatic logic [7:0] pat_byte(input int i);
        logic [31:0] p;
        p = PAT;
        return p[8*(3-i) +: 8];
    endfunction

    // Reference model: every LEN accepted bytes form one frame preceded by the sync word.
    task automatic model_build(input logic [7:0] pay[$]);
        exp_q = {};
        for (int i = 0; i < pay.size(); i++) begin
            if (i % LEN == 0)
                for (int s = 0; s < 4; s++) exp_q.push_back(pat_byte(s));
            exp_q.push_back(pay[i]);
        end
    endtask

    task automatic set_inputs(input int rmode, input int vpct);
        if (src_q.size() != 0 && int'($urandom_range(99)) < vpct) begin
            i_m_valid = 1'b1;
            i_m_data  = src_q[0];
        end else begin
            i_m_valid = 1'b0;
        end
        case (rmode)
            0:       i_s_ready = 1'b1;
            1:       i_s_ready = ~i_s_ready;
            default: i_s_ready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic drive(input string tag, input int rmode, input int vpct, input int n_out, input int budget);
        int   base;
        int   n;
        logic acc;
        base = got_q.size();
        n    = 0;
        @(posedge i_clk); #1;
        set_inputs(rmode, vpct);
        drive_start_cyc = cyc;
        while ((src_q.size() != 0 || got_q.size() - base < n_out) && n < budget) begin
            @(negedge i_clk);
            acc = i_m_valid && o_m_ready;
            @(posedge i_clk); #1;
            if (acc) void'(src_q.pop_front());
            set_inputs(rmode, vpct);
            n++;
        end
        i_m_valid = 1'b0;
        i_s_ready = 1'b1;
        n_checks++;
        if (src_q.size() != 0 || got_q.size() - base < n_out) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes want %0d", tag, got_q.size() - base, n_out);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_m_valid = 1'b1; i_m_data = 8'hA5; i_s_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++; if (o_s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", o_s_valid); end
        n_checks++; if (o_s_data !== 8'h00) begin n_fail++; $display("FAIL reset_s_data: got %02h want 00", o_s_data); end
        n_checks++; if (o_m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready: got %b want 0", o_m_ready); end
        n_checks++; if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", o_frame_start); end
        n_checks++; if (o_frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", o_frame_count); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_m_valid = 1'b0;
        @(negedge i_clk);
        n_checks++; if (o_busy !== 1'b0 || o_s_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b valid %b want 0 0", o_busy, o_s_valid); end
    endtask

    task automatic test_basic();
        int base, fbase;
        src_q = {8'h11, 8'h22, 8'h33, 8'h44};
        model_build(src_q);
        base = got_q.size(); fbase = fs_cyc.size();
        drive("basic", 0, 100, 8, 200);
        exp_frames = exp_frames + 16'd1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_byte[%0d]: got %02h want %02h", i, (got_q.size() > base + i) ? got_q[base+i] : 8'h00, exp_q[i]);
            end
        end
        n_checks++; if (got_q.size() - base != 8 || got_cyc[base+7] - got_cyc[base] != 7) begin n_fail++; $display("FAIL basic_consecutive: got span %0d want 7", got_cyc[base+7] - got_cyc[base]); end
        n_checks++; if (got_cyc[base] != drive_start_cyc + 2) begin n_fail++; $display("FAIL basic_latency: got %0d cycles want 2", got_cyc[base] - drive_start_cyc); end
        n_checks++; if (fs_cyc.size() - fbase != 1 || fs_cyc[fbase] != got_cyc[base]) begin n_fail++; $display("FAIL basic_frame_start: got %0d pulses want 1 aligned with first sync byte", fs_cyc.size() - fbase); end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL basic_frame_count: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    task automatic test_stall();
        int base, serr;
        src_q = {8'h11, 8'h22, 8'h33, 8'h44};
        model_build(src_q);
        base = got_q.size(); serr = stable_err;
        drive("stall", 1, 100, 8, 200);
        exp_frames = exp_frames + 16'd1;
        n_checks++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_byte[%0d]: got %02h want %02h", i, (got_q.size() > base + i) ? got_q[base+i] : 8'h00, exp_q[i]);
            end
        end
        n_checks++; if (stable_err != serr) begin n_fail++; $display("FAIL stall_stability: got %0d breaks want 0", stable_err - serr); end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL stall_frame_count: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    task automatic test_back_to_back();
        int base, fbase, dbase;
        src_q = {};
        for (int i = 0; i < 3 * LEN; i++) src_q.push_back(8'(8'h40 + i));
        model_build(src_q);
        base = got_q.size(); fbase = fs_cyc.size(); dbase = det_cyc.size();
        drive("b2b", 0, 100, 3 * (LEN + 4), 400);
        exp_frames = exp_frames + 16'd3;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_byte[%0d]: got %02h want %02h", i, (got_q.size() > base + i) ? got_q[base+i] : 8'h00, exp_q[i]);
            end
        end
        for (int f = 1; f < 3; f++) begin
            n_checks++;
            if (got_cyc[base + 8*f] - got_cyc[base + 8*f - 1] != 2) begin
                n_fail++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 2", f, got_cyc[base + 8*f] - got_cyc[base + 8*f - 1]);
            end
        end
        n_checks++; if (fs_cyc.size() - fbase != 3) begin n_fail++; $display("FAIL b2b_frame_start: got %0d pulses want 3", fs_cyc.size() - fbase); end
        n_checks++; if (det_cyc.size() - dbase != 3) begin n_fail++; $display("FAIL detect_count: got %0d want 3", det_cyc.size() - dbase); end
        for (int f = 0; f < 3 && det_cyc.size() - dbase == 3; f++) begin
            n_checks++;
            if (det_cyc[dbase+f] != got_cyc[base + 8*f + 3] + 1) begin
                n_fail++; $display("FAIL detect_timing[%0d]: got cycle %0d want %0d", f, det_cyc[dbase+f], got_cyc[base + 8*f + 3] + 1);
            end
        end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    task automatic test_reset_mid_frame();
        int   abase, base, n, rbase;
        logic acc;
        src_q = {8'h11, 8'h22, 8'h33, 8'h44};
        abase = acc_q.size(); rbase = acc_in_rst; n = 0;
        @(posedge i_clk); #1;
        i_m_valid = 1'b1; i_m_data = src_q[0]; i_s_ready = 1'b1;
        while (acc_q.size() - abase < 2 && n < 50) begin
            @(negedge i_clk);
            acc = i_m_valid && o_m_ready;
            @(posedge i_clk); #1;
            if (acc) void'(src_q.pop_front());
            if (src_q.size() != 0) i_m_data = src_q[0];
            n++;
        end
        n_checks++; if (acc_q.size() - abase < 2) begin n_fail++; $display("FAIL midrst_timeout: got %0d accepted want 2", acc_q.size() - abase); end
        i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_m_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_m_ready_in_reset: got %b want 0", o_m_ready); end
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_m_valid = 1'b0;
        exp_frames = 16'd0;
        @(negedge i_clk);
        n_checks++; if (acc_in_rst != rbase) begin n_fail++; $display("FAIL midrst_accept_in_reset: got %0d want 0", acc_in_rst - rbase); end
        n_checks++; if (o_s_valid !== 1'b0 || o_s_data !== 8'h00) begin n_fail++; $display("FAIL midrst_out: got valid %b data %02h want 0 00", o_s_valid, o_s_data); end
        n_checks++; if (o_busy !== 1'b0 || o_frame_start !== 1'b0 || o_m_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy %b fs %b rdy %b want 0 0 0", o_busy, o_frame_start, o_m_ready); end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL midrst_frame_count: got %0d want 0", o_frame_count); end
        src_q = {8'h55, 8'h66, 8'h77, 8'h88};
        model_build(src_q);
        base = got_q.size();
        drive("midrst", 0, 100, 8, 200);
        exp_frames = exp_frames + 16'd1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midrst_byte[%0d]: got %02h want %02h", i, (got_q.size() > base + i) ? got_q[base+i] : 8'h00, exp_q[i]);
            end
        end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL midrst_frame_count_after: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    task automatic test_wrap();
        @(negedge i_clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge i_clk);
        release dut.frame_count_q;
        @(negedge i_clk);
        exp_frames = 16'hFFFF;
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL wrap_preload: got %0d want %0d", o_frame_count, exp_frames); end
        src_q = {};
        for (int i = 0; i < LEN; i++) src_q.push_back(8'($urandom));
        drive("wrap", 0, 100, LEN + 4, 200);
        exp_frames = exp_frames + 16'd1;
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL wrap_frame_count: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    task automatic test_random();
        int         base, abase, fbase, serr;
        logic [7:0] sent[$];
        src_q = {};
        for (int i = 0; i < 6 * LEN; i++) src_q.push_back(8'($urandom));
        sent = src_q;
        model_build(sent);
        base = got_q.size(); abase = acc_q.size(); fbase = fs_cyc.size(); serr = stable_err;
        drive("random", 2, 70, exp_q.size(), 3000);
        exp_frames = exp_frames + 16'd6;
        n_checks++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL random_byte[%0d]: got %02h want %02h", i, (got_q.size() > base + i) ? got_q[base+i] : 8'h00, exp_q[i]);
            end
        end
        n_checks++; if (acc_q.size() - abase != sent.size()) begin n_fail++; $display("FAIL random_accepted: got %0d want %0d", acc_q.size() - abase, sent.size()); end
        n_checks++; if (stable_err != serr) begin n_fail++; $display("FAIL random_stability: got %0d breaks want 0", stable_err - serr); end
        n_checks++; if (fs_cyc.size() - fbase != 6) begin n_fail++; $display("FAIL random_frame_start: got %0d want 6", fs_cyc.size() - fbase); end
        n_checks++; if (o_frame_count !== exp_frames) begin n_fail++; $display("FAIL random_frame_count: got %0d want %0d", o_frame_count, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
